uart_hw_ctrl: RTL and testbench
===============================

// Module: uart_hw_ctrl
// PURPOSE
//  Bus-master sequencer that owns the pi1 port of a uart_hw device. After reset it programs the
//  line speed, disables the device interrupt and captures PHYCLKFREQ/BUFSZ. It then round-robin
//  polls TX/RX buffer usage to move bytes between simple valid/ready byte streams and the device.
//  It lets a core without an interrupt path use the UART without ever overrunning its TX buffer.
// PARAMETERS
//  ARCHBITSZ    32   bus data width (16/32/64); ADDRBITSZ = ARCHBITSZ-clog2(ARCHBITSZ/8)
//  BASEADDR     0    word address of the uart_hw device, driven on m_addr_o
//  CLKSPERBIT   868  reset value of clock-cycles-per-bit written by SETSPEED; ARCHBITSZ-2 bits
// PORTS
//  rst_i          in   1            synchronous reset, active-high
//  clk_i          in   1            sole clock; all logic on posedge clk_i
//  m_op_o         out  2            pi1 op: 00 NOOP, 01 WR, 10 RD, 11 RW (command)
//  m_addr_o       out  ADDRBITSZ    always BASEADDR
//  m_data_o       out  ARCHBITSZ    write byte, or command word {cmd[1:0],arg[ARCHBITSZ-3:0]}
//  m_data_i       in   ARCHBITSZ    device read/command result, valid the cycle after acceptance
//  m_sel_o        out  ARCHBITSZ/8  all ones
//  m_rdy_i        in   1            device ready; op is accepted when m_op_o!=NOOP && m_rdy_i
//  cfg_speed_i    in   ARCHBITSZ-2  new clock-cycles-per-bit
//  cfg_we_i       in   1            1-cycle strobe: latch cfg_speed_i and schedule a re-program
//  init_done_o    out  1            high once the first SETSPEED + SETINTERRUPT pair completes
//  phyclkfreq_o   out  ARCHBITSZ    result captured from the last SETSPEED
//  bufsz_o        out  ARCHBITSZ    result captured from SETINTERRUPT (device BUFSZ)
//  tx_data_i      in   8            byte to transmit
//  tx_valid_i     in   1            tx_data_i valid
//  tx_ready_o     out  1            1-cycle pulse in the cycle the WR op carrying tx_data_i is accepted
//  rx_data_o      out  8            received byte (1-entry holding register)
//  rx_valid_o     out  1            holding register full
//  rx_ready_i     in   1            consumer takes the byte when rx_valid_o && rx_ready_i
// BEHAVIOUR
//  - Reset: state=SPD; all outputs 0 (m_op_o=NOOP), except m_addr_o=BASEADDR and m_sel_o=all 1s.
//    Speed register=CLKSPERBIT. Reset mid-transaction aborts it; no completion or capture.
//  - Command words: GETUSAGE cmd=0 (arg bit0: 1=TX, 0=RX); SETINTERRUPT cmd=1 (arg=0);
//    SETSPEED cmd=2 (arg=speed register).
//  - Op states (SPD,INT,TXU,RXU,WR,RD) drive m_op_o/m_data_o and hold them stable until accepted.
//  - Each accepted op except WR moves to a 1-cycle capture state (xW) that registers m_data_i.
//  - FSM: SPD->SPDW (phyclkfreq_o<=m_data_i) -> INT -> INTW (bufsz_o<=m_data_i; init_done_o<=1)
//    -> IDLE.
//  - IDLE: if reprogram pending -> SPD (clears pending). Otherwise go to the side pointed at by
//    the round-robin bit, then flip it.
//    TX side: only when tx_valid_i, else try RX. RX side: only when !rx_valid_o, else try TX.
//    Neither side eligible: stay IDLE.
//  - TXU->TXUW: if m_data_i<bufsz_o && tx_valid_i -> WR, else IDLE.
//    WR: m_data_o={0,tx_data_i}; on accept pulse tx_ready_o -> IDLE.
//  - RXU->RXUW: if m_data_i!=0 -> RD, else IDLE.
//    RD->RDW: rx_data_o<=m_data_i[7:0], rx_valid_o<=1 -> IDLE.
//  - Safe because TX usage only falls and RX usage only rises between poll and access, so WR
//    never hits a full TX buffer and RD never hits an empty RX buffer.
//  - rx_valid_o clears on rx_ready_i handshake. It is never set while already set (RX side gated).
//  - cfg_we_i in any state latches speed and sets pending; the in-flight sequence completes first.
//    A second strobe before SPD overwrites speed (last wins). In SPDW the SETSPEED just issued
//    used the old value, so pending stays set and SPD repeats.
//    After a reprogram, SPDW returns to IDLE (INT is not re-run).
//  - tx_valid_i dropping during TXUW aborts to IDLE. tx_data_i must be stable while tx_valid_i is
//    high and no ready pulse has occurred.
//  - Min latency IDLE->byte written: 4 cycles with m_rdy_i=1.
// TESTING
//  - Reset, m_rdy_i=1 -> cycle1 RW 0x80000364 (ARCHBITSZ=32); m_data_i=100e6 -> phyclkfreq_o;
//    then RW 0x40000000; BUFSZ=2 -> bufsz_o=2, init_done_o=1.
//  - tx_valid_i=1 with 0x41, TX usage returns 0 -> RW 0x00000001, WR 0x41, tx_ready_o 1 cycle.
//    Usage returns 2 -> no WR, repolls.
//  - RX usage=1, m_data_i=0x5A after RD -> rx_valid_o=1, rx_data_o=0x5A. No further RX poll until
//    rx_ready_i=1.
//  - m_rdy_i held low 5 cycles during WR -> m_op_o/m_data_o stable; tx_ready_o only on the accept
//    cycle.
//  - cfg_we_i=1, speed 434, during RD -> RD completes, then RW 0x800001B2; init_done_o stays 1.
//  - rst_i asserted mid-WR -> m_op_o=NOOP next cycle, no tx_ready_o, SPD sequence restarts.

Source files
------------

// File: rtl/uart_hw_ctrl.sv
// pi1 bus-master sequencer for a uart_hw device: programs speed and interrupt after reset,
// then round-robin polls TX/RX buffer usage to move bytes between byte streams and the device.
module uart_hw_ctrl #(
   parameter int ARCHBITSZ  = 32,
   parameter int BASEADDR   = 0,
   parameter int CLKSPERBIT = 868,
   localparam int ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ / 8)
) (
   input  logic                     rst_i,
   input  logic                     clk_i,
   output logic [1:0]               m_op_o,
   output logic [ADDRBITSZ-1:0]     m_addr_o,
   output logic [ARCHBITSZ-1:0]     m_data_o,
   input  logic [ARCHBITSZ-1:0]     m_data_i,
   output logic [ARCHBITSZ/8-1:0]   m_sel_o,
   input  logic                     m_rdy_i,
   input  logic [ARCHBITSZ-3:0]     cfg_speed_i,
   input  logic                     cfg_we_i,
   output logic                     init_done_o,
   output logic [ARCHBITSZ-1:0]     phyclkfreq_o,
   output logic [ARCHBITSZ-1:0]     bufsz_o,
   input  logic [7:0]               tx_data_i,
   input  logic                     tx_valid_i,
   output logic                     tx_ready_o,
   output logic [7:0]               rx_data_o,
   output logic                     rx_valid_o,
   input  logic                     rx_ready_i
);

   typedef enum logic [3:0] {
      S_IDLE, S_SPD, S_SPDW, S_INT, S_INTW, S_TXU, S_TXUW, S_WR, S_RXU, S_RXUW, S_RD, S_RDW
   } state_t;

   localparam logic [1:0] OP_NOOP = 2'b00;
   localparam logic [1:0] OP_WR   = 2'b01;
   localparam logic [1:0] OP_RD   = 2'b10;
   localparam logic [1:0] OP_RW   = 2'b11;

   localparam logic [1:0] CMD_GETUSAGE = 2'd0;
   localparam logic [1:0] CMD_SETINTR  = 2'd1;
   localparam logic [1:0] CMD_SETSPEED = 2'd2;

   state_t                 state_q, state_d;
   logic                   pending_q, pending_d;
   logic [ARCHBITSZ-3:0]   speed_q, speed_d;
   logic                   rr_q, rr_d;
   logic [ARCHBITSZ-1:0]   phy_q, phy_d;
   logic [ARCHBITSZ-1:0]   bufsz_q, bufsz_d;
   logic                   init_q, init_d;
   logic [7:0]             rxd_q, rxd_d;
   logic                   rxv_q, rxv_d;
   logic [1:0]             m_op_q, m_op_d;
   logic [ARCHBITSZ-1:0]   m_data_q, m_data_d;
   logic                   accept;

   function automatic logic [ARCHBITSZ-1:0] cmd_word(input logic [1:0] cmd,
                                                      input logic [ARCHBITSZ-3:0] arg);
      return {cmd, arg};
   endfunction

   assign accept = (m_op_q != OP_NOOP) && m_rdy_i;

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q | cfg_we_i;
      speed_d   = cfg_we_i ? cfg_speed_i : speed_q;
      rr_d      = rr_q;
      phy_d     = phy_q;
      bufsz_d   = bufsz_q;
      init_d    = init_q;
      rxd_d     = rxd_q;
      rxv_d     = rxv_q & ~rx_ready_i;
      m_op_d    = m_op_q;
      m_data_d  = m_data_q;

      case (state_q)
         S_IDLE: begin
            if (pending_q) begin
               state_d   = S_SPD;
               pending_d = cfg_we_i;
            end else if (tx_valid_i && (!rr_q || rxv_q)) begin
               state_d = S_TXU;
               rr_d    = ~rr_q;
            end else if (!rxv_q) begin
               state_d = S_RXU;
               rr_d    = ~rr_q;
            end
         end
         S_SPD:  if (accept) state_d = S_SPDW;
         S_SPDW: begin
            phy_d = m_data_i;
            // The SETSPEED just issued carried the old speed if a strobe arrived meanwhile.
            if (pending_q) begin
               state_d   = S_SPD;
               pending_d = cfg_we_i;
            end else begin
               state_d = init_q ? S_IDLE : S_INT;
            end
         end
         S_INT:  if (accept) state_d = S_INTW;
         S_INTW: begin
            bufsz_d = m_data_i;
            init_d  = 1'b1;
            state_d = S_IDLE;
         end
         S_TXU:  if (accept) state_d = S_TXUW;
         S_TXUW: state_d = (m_data_i < bufsz_q && tx_valid_i) ? S_WR : S_IDLE;
         S_WR:   if (accept) state_d = S_IDLE;
         S_RXU:  if (accept) state_d = S_RXUW;
         S_RXUW: state_d = (m_data_i != '0) ? S_RD : S_IDLE;
         S_RD:   if (accept) state_d = S_RDW;
         S_RDW: begin
            rxd_d   = m_data_i[7:0];
            rxv_d   = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Bus op/data are registered on state entry so they stay frozen until accepted.
      if (state_d != state_q || m_op_q == OP_NOOP) begin
         m_op_d   = OP_NOOP;
         m_data_d = '0;
         case (state_d)
            S_SPD: begin
               m_op_d   = OP_RW;
               m_data_d = cmd_word(CMD_SETSPEED, speed_q);
            end
            S_INT: begin
               m_op_d   = OP_RW;
               m_data_d = cmd_word(CMD_SETINTR, '0);
            end
            S_TXU: begin
               m_op_d   = OP_RW;
               m_data_d = cmd_word(CMD_GETUSAGE, (ARCHBITSZ-2)'(1));
            end
            S_RXU: begin
               m_op_d   = OP_RW;
               m_data_d = cmd_word(CMD_GETUSAGE, '0);
            end
            S_WR: begin
               m_op_d   = OP_WR;
               m_data_d = ARCHBITSZ'(tx_data_i);
            end
            S_RD:    m_op_d = OP_RD;
            default: m_op_d = OP_NOOP;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_SPD;
         pending_q <= 1'b0;
         speed_q   <= (ARCHBITSZ-2)'(CLKSPERBIT);
         rr_q      <= 1'b0;
         phy_q     <= '0;
         bufsz_q   <= '0;
         init_q    <= 1'b0;
         rxd_q     <= '0;
         rxv_q     <= 1'b0;
         m_op_q    <= OP_NOOP;
         m_data_q  <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         speed_q   <= speed_d;
         rr_q      <= rr_d;
         phy_q     <= phy_d;
         bufsz_q   <= bufsz_d;
         init_q    <= init_d;
         rxd_q     <= rxd_d;
         rxv_q     <= rxv_d;
         m_op_q    <= m_op_d;
         m_data_q  <= m_data_d;
      end
   end

   assign m_op_o       = m_op_q;
   assign m_addr_o     = ADDRBITSZ'(BASEADDR);
   assign m_data_o     = m_data_q;
   assign m_sel_o      = '1;
   assign init_done_o  = init_q;
   assign phyclkfreq_o = phy_q;
   assign bufsz_o      = bufsz_q;
   assign tx_ready_o   = (state_q == S_WR) && accept;
   assign rx_data_o    = rxd_q;
   assign rx_valid_o   = rxv_q;

endmodule

// File: tb/tb_uart_hw_ctrl.sv
// Bench for uart_hw_ctrl: a behavioural uart_hw device (buffer fill counters and an RX byte
// FIFO) answers the bus; byte streams are checked through scoreboard queues.
module tb_uart_hw_ctrl;

   localparam int          BUFSZ    = 2;
   localparam logic [31:0] PHY_INIT = 32'd100_000_000;
   localparam logic [31:0] PHY_NEW  = 32'd50_000_000;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic [1:0]  m_op_o;
   logic [29:0] m_addr_o;
   logic [31:0] m_data_o;
   logic [31:0] m_data_i;
   logic [3:0]  m_sel_o;
   logic        m_rdy_i;
   logic [29:0] cfg_speed_i = '0;
   logic        cfg_we_i = 1'b0;
   logic        init_done_o;
   logic [31:0] phyclkfreq_o;
   logic [31:0] bufsz_o;
   logic [7:0]  tx_data_i;
   logic        tx_valid_i;
   logic        tx_ready_o;
   logic [7:0]  rx_data_o;
   logic        rx_valid_o;
   logic        rx_ready_i;

   always #5 clk_i = ~clk_i;

   uart_hw_ctrl #(.ARCHBITSZ(32), .BASEADDR(0), .CLKSPERBIT(868)) dut (
      .rst_i(rst_i), .clk_i(clk_i), .m_op_o(m_op_o), .m_addr_o(m_addr_o),
      .m_data_o(m_data_o), .m_data_i(m_data_i), .m_sel_o(m_sel_o), .m_rdy_i(m_rdy_i),
      .cfg_speed_i(cfg_speed_i), .cfg_we_i(cfg_we_i), .init_done_o(init_done_o),
      .phyclkfreq_o(phyclkfreq_o), .bufsz_o(bufsz_o), .tx_data_i(tx_data_i),
      .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o), .rx_data_o(rx_data_o),
      .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // scoreboard queues
   logic [7:0]  tx_src[$];
   logic [7:0]  tx_exp[$];
   logic [7:0]  rx_src[$];
   logic [7:0]  rx_exp[$];
   logic [31:0] cmd_exp[$];

   // device model and stimulus knobs
   int          tx_fill = 0;
   int          rx_avail = 0;
   int          tx_budget = 0;
   bit          rdy_rand = 0, tx_drain_en = 0, rx_arr_en = 0, tx_en = 0, rx_rdy_en = 0;
   bit          hold_on_wr = 0;
   logic [31:0] phy_val = PHY_INIT;

   // device: drives m_rdy_i/m_data_i, judges every accepted op
   initial begin
      logic [1:0]  prev_op;
      logic [31:0] prev_data;
      logic [31:0] resp;
      logic [7:0]  b;
      bit          prev_wait, resp_pending;
      prev_op = '0; prev_data = '0; resp = '0; prev_wait = 0; resp_pending = 0;
      m_rdy_i = 1'b0;
      m_data_i = '0;
      forever begin
         @(negedge clk_i);
         m_data_i = resp_pending ? resp : 32'($urandom());
         resp_pending = 0;
         if (hold_on_wr && m_op_o == 2'b01) m_rdy_i = 1'b0;
         else m_rdy_i = rdy_rand ? ($urandom_range(0, 9) < 7) : 1'b1;
         if (tx_drain_en && tx_fill > 0 && $urandom_range(0, 3) == 0) tx_fill--;
         if (rx_arr_en && rx_avail < 6 && $urandom_range(0, 4) == 0) begin
            rx_avail++;
            rx_src.push_back(8'($urandom()));
         end
         #2;
         if (prev_wait) begin
            check("hold_op", 64'(m_op_o), 64'(prev_op));
            check("hold_data", 64'(m_data_o), 64'(prev_data));
         end
         if (!rst_i && m_op_o != 2'b00 && m_rdy_i) begin
            check("addr_sel", 64'({m_addr_o, m_sel_o}), 64'({30'd0, 4'hF}));
            case (m_op_o)
               2'b11: begin
                  if (m_data_o[31:30] == 2'd0) begin
                     check("usage_arg", 64'(m_data_o[29:1]), 64'(0));
                     if (m_data_o[0]) resp = 32'(tx_fill);
                     else begin
                        check("rx_poll_while_full", 64'(rx_valid_o), 64'(0));
                        resp = 32'(rx_avail);
                     end
                  end else begin
                     check("cmd_word", 64'(m_data_o),
                           64'(cmd_exp.size() != 0 ? cmd_exp.pop_front() : 32'hFFFF_FFFF));
                     resp = (m_data_o[31:30] == 2'd2) ? phy_val : 32'(BUFSZ);
                  end
                  resp_pending = 1;
               end
               2'b01: begin
                  check("wr_room", 64'(tx_fill < BUFSZ), 64'(1));
                  check("wr_byte", 64'(m_data_o),
                        64'(tx_exp.size() != 0 ? {24'd0, tx_exp.pop_front()} : 32'hFFFF_FFFF));
                  check("tx_ready_on_wr", 64'(tx_ready_o), 64'(1));
                  tx_fill++;
               end
               default: begin
                  check("rd_avail", 64'(rx_avail > 0), 64'(1));
                  if (rx_avail > 0) begin
                     rx_avail--;
                     b = rx_src.pop_front();
                     rx_exp.push_back(b);
                     resp = (32'($urandom()) & 32'hFFFF_FF00) | {24'd0, b};
                     resp_pending = 1;
                  end
               end
            endcase
         end
         if (tx_ready_o && !(m_op_o == 2'b01 && m_rdy_i))
            check("tx_ready_spurious", 64'(tx_ready_o), 64'(0));
         prev_wait = !rst_i && m_op_o != 2'b00 && !m_rdy_i;
         prev_op   = m_op_o;
         prev_data = m_data_o;
      end
   end

   // stream stimulus: TX bytes (expected bytes pushed on presentation), RX consumer ready
   initial begin
      bit tx_hs;
      tx_hs = 0;
      tx_valid_i = 1'b0;
      tx_data_i = '0;
      rx_ready_i = 1'b0;
      forever begin
         @(negedge clk_i);
         if (tx_hs) tx_valid_i = 1'b0;
         if (!tx_valid_i) begin
            if (tx_src.size() != 0) begin
               tx_data_i = tx_src.pop_front();
               tx_valid_i = 1'b1;
               tx_exp.push_back(tx_data_i);
            end else if (tx_en && tx_budget > 0 && $urandom_range(0, 2) == 0) begin
               tx_data_i = 8'($urandom());
               tx_valid_i = 1'b1;
               tx_exp.push_back(tx_data_i);
               tx_budget--;
            end
         end
         rx_ready_i = rx_rdy_en ? 1'($urandom_range(0, 1)) : 1'b0;
         #2;
         tx_hs = tx_valid_i && tx_ready_o;
      end
   end

   // RX monitor
   initial begin
      forever begin
         @(negedge clk_i);
         #2;
         if (!rst_i && rx_valid_o && rx_ready_i)
            check("rx_byte", 64'(rx_data_o),
                  64'(rx_exp.size() != 0 ? {1'b0, rx_exp.pop_front()} : 9'h1FF));
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(negedge clk_i);
         #3;
      end
   endtask

   task automatic wait_init(input string name);
      for (int i = 0; i < 60 && !init_done_o; i++) cyc(1);
      check(name, 64'(init_done_o), 64'(1));
   endtask

   initial begin
      cyc(3);
      check("rst_op", 64'(m_op_o), 64'(0));
      check("rst_data", 64'(m_data_o), 64'(0));
      check("rst_addr_sel", 64'({m_addr_o, m_sel_o}), 64'({30'd0, 4'hF}));
      check("rst_outs", 64'({init_done_o, tx_ready_o, rx_valid_o}), 64'(0));
      check("rst_regs", 64'({phyclkfreq_o, bufsz_o}), 64'(0));
      cmd_exp.push_back(32'h8000_0364);
      cmd_exp.push_back(32'h4000_0000);
      @(negedge clk_i);
      rst_i = 1'b0;
      cyc(1);
      check("first_op", 64'(m_op_o), 64'(3));
      check("first_data", 64'(m_data_o), 64'(32'h8000_0364));
      wait_init("init_timeout");
      check("phyclkfreq", 64'(phyclkfreq_o), 64'(PHY_INIT));
      check("bufsz", 64'(bufsz_o), 64'(BUFSZ));
      check("init_cmds_left", 64'(cmd_exp.size()), 64'(0));

      // single byte into an empty TX buffer
      tx_src.push_back(8'h41);
      for (int i = 0; i < 40 && (tx_exp.size() != 0 || tx_src.size() != 0); i++) cyc(1);
      check("tx41_written", 64'(tx_exp.size() + tx_src.size()), 64'(0));

      // full TX buffer blocks the write until it drains
      tx_fill = BUFSZ;
      tx_src.push_back(8'h42);
      cyc(30);
      check("tx_full_blocks", 64'(tx_exp.size()), 64'(1));
      tx_fill = 0;
      for (int i = 0; i < 40 && tx_exp.size() != 0; i++) cyc(1);
      check("tx42_written", 64'(tx_exp.size()), 64'(0));

      // RX byte lands in the holding register; no more RX traffic while it is full
      rx_src.push_back(8'h5A);
      rx_avail = 1;
      for (int i = 0; i < 40 && !rx_valid_o; i++) cyc(1);
      check("rx_valid", 64'(rx_valid_o), 64'(1));
      check("rx_data", 64'(rx_data_o), 64'(8'h5A));
      rx_src.push_back(8'h77);
      rx_avail = 1;
      cyc(30);
      check("rx_gated", 64'(rx_avail), 64'(1));
      rx_rdy_en = 1;
      for (int i = 0; i < 80 && (rx_exp.size() != 0 || rx_avail != 0 || rx_valid_o); i++) cyc(1);
      check("rx_drained", 64'(rx_exp.size() + rx_avail), 64'(0));

      // randomized traffic
      rdy_rand = 1; tx_drain_en = 1; rx_arr_en = 1; tx_en = 1; tx_budget = 200;
      cyc(300);

      // reprogram the speed while a RD is outstanding
      for (int i = 0; i < 2000 && m_op_o != 2'b10; i++) cyc(1);
      check("rd_seen", 64'(m_op_o), 64'(2));
      cfg_speed_i = 30'd434;
      cfg_we_i = 1'b1;
      phy_val = PHY_NEW;
      cmd_exp.push_back(32'h8000_01B2);
      @(negedge clk_i);
      cfg_we_i = 1'b0;
      for (int i = 0; i < 200 && cmd_exp.size() != 0; i++) cyc(1);
      check("respeed_issued", 64'(cmd_exp.size()), 64'(0));
      cyc(3);
      check("respeed_phy", 64'(phyclkfreq_o), 64'(PHY_NEW));
      check("respeed_init_kept", 64'(init_done_o), 64'(1));
      cyc(200);

      // stall a WR, then reset in the middle of it
      hold_on_wr = 1;
      if (tx_budget == 0) tx_budget = 1;
      for (int i = 0; i < 3000 && m_op_o != 2'b01; i++) cyc(1);
      check("wr_seen", 64'(m_op_o), 64'(1));
      for (int i = 0; i < 5; i++) begin
         cyc(1);
         check("wr_stall_no_ready", 64'(tx_ready_o), 64'(0));
      end
      @(negedge clk_i);
      rst_i = 1'b1;
      cyc(1);
      check("rst_mid_wr_op", 64'(m_op_o), 64'(0));
      check("rst_mid_wr_outs", 64'({tx_ready_o, init_done_o, rx_valid_o}), 64'(0));
      hold_on_wr = 0;
      rx_exp.delete();
      phy_val = PHY_INIT;
      cmd_exp.delete();
      cmd_exp.push_back(32'h8000_0364);
      cmd_exp.push_back(32'h4000_0000);
      @(negedge clk_i);
      rst_i = 1'b0;
      wait_init("reinit_timeout");
      check("reinit_phy", 64'(phyclkfreq_o), 64'(PHY_INIT));
      cyc(400);

      // stop sources and drain everything
      tx_en = 0; rx_arr_en = 0;
      for (int i = 0; i < 4000 && (tx_exp.size() != 0 || tx_src.size() != 0 || tx_valid_i ||
                                   rx_exp.size() != 0 || rx_avail != 0 || rx_valid_o); i++)
         cyc(1);
      check("final_tx_drain", 64'(tx_exp.size() + tx_src.size()), 64'(0));
      check("final_rx_drain", 64'(rx_exp.size() + rx_avail), 64'(0));
      check("final_cmds", 64'(cmd_exp.size()), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
